// File: rtl/mul_share_pkg.sv
// Shared types and default sizes for the shared multiply/accumulate arbiter.
// Pure declarations: no logic, no latency.
// Backpressure is not applicable at this level.
package mul_share_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 4;
   localparam int ACCW_DEF = 12;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MAC  = 2'b01,
      OP_MSUB = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_MULT  = 2'b01,
      S_ACCUM = 2'b10,
      S_RESP  = 2'b11
   } state_t;

endpackage

// File: rtl/mul_share_rr_arbiter.sv
// Round-robin grant: picks the first active request after ptr_i, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the grant is honoured.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o
);

   logic           found;
   logic [IDW-1:0] idx;

   // Scan ptr+1 .. ptr+NREQ (mod NREQ); the last served requester is checked last.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one WxW multiplier and an add/sub accumulator among NREQ requesters.
// Latency: accept at T, resp_valid at T+3; next accept no earlier than T+4.
// Backpressure: a stalled response holds the datapath; req_ready stays low until it drains.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int ACCW = ACCW_DEF,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [W*NREQ-1:0]    req_a,
   input  logic [W*NREQ-1:0]    req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [ACCW-1:0]      resp_data
);

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, id_q, gnt_idx;
   logic [NREQ-1:0] gnt;
   op_t             op_q;
   logic [W-1:0]    a_q, b_q, sel_a, sel_b;
   logic [1:0]      sel_op;
   logic [2*W-1:0]  mult;
   logic [ACCW-1:0] prod_q, res_q, res_d;
   logic [ACCW-1:0] acc_q [NREQ];
   logic            take;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // req_ready is a subset of req_valid, so any ready bit is a handshake.
   assign take = |req_ready;

   // Unsigned full-width product, zero-extended into the accumulator width.
   assign mult = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

   // Select the granted requester's op and operands.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[W*i +: W];
            sel_b  = req_b[W*i +: W];
         end
      end
   end

   // Result of the latched op; arithmetic wraps modulo 2^ACCW.
   always_comb begin
      case (op_q)
         OP_MUL:  res_d = prod_q;
         OP_MAC:  res_d = acc_q[id_q] + prod_q;
         OP_MSUB: res_d = acc_q[id_q] - prod_q;
         default: res_d = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: fixed MULT/ACCUM pipeline, RESP waits for the consumer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (take) state_d = S_MULT;
         S_MULT:  state_d = S_ACCUM;
         S_ACCUM: state_d = S_RESP;
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: grants only in IDLE; everything forced low while reset is asserted.
   always_comb begin
      req_ready  = '0;
      resp_valid = 1'b0;
      resp_id    = '0;
      resp_data  = '0;
      if (!reset) begin
         if (state_q == S_IDLE) req_ready = gnt;
         if (state_q == S_RESP) resp_valid = 1'b1;
         resp_id   = id_q;
         resp_data = res_q;
      end
   end

   // Datapath: capture at handshake, multiply, then accumulate into the owner's acc.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= IDW'(NREQ - 1);
         id_q   <= '0;
         op_q   <= OP_MUL;
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         res_q  <= '0;
         for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
      end else begin
         if (take) begin
            ptr_q <= gnt_idx;
            id_q  <= gnt_idx;
            op_q  <= op_t'(sel_op);
            a_q   <= sel_a;
            b_q   <= sel_b;
         end
         if (state_q == S_MULT) prod_q <= ACCW'(mult);
         if (state_q == S_ACCUM) begin
            res_q <= res_d;
            if (op_q != OP_MUL) acc_q[id_q] <= res_d;
         end
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-level reference model checked every cycle,
// plus scripted scenarios with hand-computed expected values.
// Randomized phase mixes valids, ops, operands, response stalls and resets.
module tb_mul_share_arbiter;

   localparam int N    = 4;
   localparam int W    = 4;
   localparam int AW   = 12;
   localparam int MASK = (1 << AW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready;
   logic [2*N-1:0]  req_op;
   logic [W*N-1:0]  req_a, req_b;
   logic            resp_valid, resp_ready;
   logic [1:0]      resp_id;
   logic [AW-1:0]   resp_data;

   always #5 clk = ~clk;

   mul_share_arbiter #(.NREQ(N), .W(W), .ACCW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data)
   );

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;

   // Reference model: one outstanding transaction, result computed at acceptance.
   int m_acc [N];
   bit m_busy;
   int m_age, m_id, m_res, m_last;

   // Observed events of the most recent tick.
   bit ev_acc, ev_resp;
   int ev_g, ev_id, ev_data;

   task automatic chk(string nm, int act, int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: inputs are already driven; check outputs, advance model, wait.
   task automatic tick();
      int g, a, b, op, prod, i;
      #1;
      ev_acc  = |(req_ready & req_valid);
      ev_g    = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) ev_g = k;
      ev_resp = resp_valid && resp_ready;
      ev_id   = int'(resp_id);
      ev_data = int'(resp_data);
      if (reset) begin
         chk("req_ready in reset", int'(req_ready), 0);
         chk("resp_valid in reset", int'(resp_valid), 0);
         chk("resp_id in reset", int'(resp_id), 0);
         chk("resp_data in reset", int'(resp_data), 0);
         m_busy = 0;
         m_last = N - 1;
         for (int k = 0; k < N; k++) m_acc[k] = 0;
      end else if (!m_busy) begin
         g = -1;
         for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (g < 0 && req_valid[i]) g = i;
         end
         chk("req_ready grant", int'(req_ready), (g < 0) ? 0 : (1 << g));
         chk("resp_valid idle", int'(resp_valid), 0);
         if (g >= 0) begin
            a    = int'(req_a[g*W +: W]);
            b    = int'(req_b[g*W +: W]);
            op   = int'(req_op[2*g +: 2]);
            prod = a * b;
            case (op)
               0: m_res = prod;
               1: begin m_res = (m_acc[g] + prod) & MASK; m_acc[g] = m_res; end
               2: begin m_res = (m_acc[g] - prod) & MASK; m_acc[g] = m_res; end
               default: begin m_res = 0; m_acc[g] = 0; end
            endcase
            m_id   = g;
            m_last = g;
            m_busy = 1;
            m_age  = 1;
         end
      end else begin
         chk("req_ready busy", int'(req_ready), 0);
         chk("resp_valid", int'(resp_valid), (m_age >= 3) ? 1 : 0);
         if (m_age >= 3) begin
            chk("resp_id", int'(resp_id), m_id);
            chk("resp_data", int'(resp_data), m_res);
            if (resp_ready) m_busy = 0;
         end
         m_age++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (6) tick();
   endtask

   task automatic set_req(int r, int op, int a, int b);
      logic [1:0]   o2;
      logic [W-1:0] aw, bw;
      o2 = 2'(op);
      aw = W'(a);
      bw = W'(b);
      req_op[2*r +: 2] = o2;
      req_a[W*r +: W]  = aw;
      req_b[W*r +: W]  = bw;
   endtask

   // Single request from requester r, checked against a hand-computed result and latency.
   task automatic issue(int r, int op, int a, int b, int exp);
      int t_acc, t_resp, got, gid;
      t_acc = -1; t_resp = -1; got = -1; gid = -1;
      req_valid = '0;
      req_valid[r] = 1'b1;
      set_req(r, op, a, b);
      resp_ready = 1'b1;
      for (int n = 0; n < 16 && t_resp < 0; n++) begin
         tick();
         if (ev_acc && t_acc < 0) begin t_acc = cyc - 1; req_valid = '0; end
         if (ev_resp) begin t_resp = cyc - 1; got = ev_data; gid = ev_id; end
      end
      chk("response seen", (t_resp >= 0) ? 1 : 0, 1);
      chk("literal resp_data", got, exp);
      chk("literal resp_id", gid, r);
      chk("accept-to-response latency", t_resp - t_acc, 3);
   endtask

   int grants [6];
   int ng, t_hs, nwait;

   initial begin
      reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
      m_busy = 0; m_last = N - 1; m_age = 0; m_id = 0; m_res = 0;
      for (int k = 0; k < N; k++) m_acc[k] = 0;

      // Reset, then a plain multiply at full operand range.
      do_reset();
      issue(0, 0, 15, 15, 225);

      // Private accumulator chain on requester 1.
      issue(1, 1, 3, 4, 12);
      issue(1, 1, 5, 5, 37);
      issue(1, 2, 2, 2, 33);
      issue(1, 3, 7, 9, 0);
      issue(1, 1, 1, 1, 1);
      drain();

      // All requesters valid: strict rotation starting at 0.
      do_reset();
      req_valid = '1; resp_ready = 1'b1; ng = 0;
      for (int n = 0; n < 60 && ng < 6; n++) begin
         for (int r = 0; r < N; r++) set_req(r, r, $urandom_range(0, 15), $urandom_range(0, 15));
         tick();
         if (ev_acc) begin grants[ng] = ev_g; ng++; end
      end
      chk("rotation grant count", ng, 6);
      for (int k = 0; k < 6; k++) chk("rotation order", grants[k], k % N);
      drain();

      // Underflow and overflow wrap on requester 2.
      do_reset();
      issue(2, 2, 1, 1, 4095);
      issue(2, 1, 15, 15, 224);
      issue(2, 1, 15, 15, 449);
      drain();

      // Response stall with competing requesters; next grant right after handshake.
      req_valid = '1; resp_ready = 1'b0;
      for (int r = 0; r < N; r++) set_req(r, 1, r + 1, 3);
      nwait = 0;
      while (!resp_valid && nwait < 12) begin tick(); nwait++; end
      chk("stall reached RESP", int'(resp_valid), 1);
      repeat (5) tick();
      resp_ready = 1'b1;
      tick();
      chk("stall handshake", ev_resp ? 1 : 0, 1);
      t_hs = cyc - 1;
      tick();
      chk("grant right after handshake", ev_acc ? 1 : 0, 1);
      chk("grant cycle offset", (cyc - 1) - t_hs, 1);
      drain();

      // Reset in the middle of an operation drops it and clears accumulators.
      do_reset();
      issue(3, 1, 5, 10, 50);
      req_valid = '0; req_valid[3] = 1'b1; set_req(3, 1, 1, 1);
      nwait = 0;
      ev_acc = 0;
      while (!ev_acc && nwait < 8) begin tick(); nwait++; end
      chk("mid-op accept", ev_acc ? 1 : 0, 1);
      req_valid = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ng = 0;
      for (int n = 0; n < 6; n++) begin tick(); if (resp_valid) ng++; end
      chk("dropped response count", ng, 0);
      issue(3, 1, 1, 1, 1);
      req_valid = '1;
      nwait = 0;
      ev_acc = 0;
      while (!ev_acc && nwait < 8) begin tick(); nwait++; end
      chk("first grant after reset", ev_g, 0);
      drain();

      // Randomized traffic with stalls and occasional resets.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         req_valid  = N'($urandom);
         req_op     = (2*N)'($urandom);
         req_a      = (W*N)'($urandom);
         req_b      = (W*N)'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         reset      = ($urandom_range(0, 249) == 0);
         tick();
      end
      reset = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
